// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory response block.
package dmem_pkg;
    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;
    localparam int WORD_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read sampled by the owner.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);
    // Contents are deliberately not reset so they survive a core reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder with pipeline stall (IDLE/WAIT/RESP FSM).
// Optional DMEM_RESP_CHK_EN flags misaligned / out-of-range accesses on err_o.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               we_q, we_d;

    logic               commit;
    logic               illegal;
    logic               arr_we;
    logic [AW-1:0]      idx;
    logic [WORD_W-1:0]  arr_rdata;

    assign idx    = addr_q[AW+1:2];
    // The transaction resolves on the edge that leaves WAIT.
    assign commit = (state_q == ST_WAIT) && (cnt_q == '0);
    assign arr_we = commit && we_q && !illegal;

`ifdef DMEM_RESP_CHK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);
    logic err_q;

    assign illegal = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= illegal;
        end else if (state_q == ST_RESP) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_addr;

    assign illegal     = 1'b0;
    assign unused_addr = ^{addr_q[31:AW+2], addr_q[1:0]};
    assign err_o       = 1'b0;
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        stall_o  = 1'b0;
        rvalid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_o = req_i;
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = we_i;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // req_i is not looked at here: a flushed request still completes.
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (illegal) begin
                        rdata_d = '0;
                    end else if (!we_q) begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                rvalid_o = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata_o = rdata_q;
endmodule
